// File: rtl/matrix_bus_pkg.sv
// ---------------------------------------------------------------------------
// matrix_bus_pkg
// Shared definitions for targets on the matrix bus: bus widths, the
// address[15:12] device-select codes, the register offsets decoded from
// address[3:0], and the STATUS word bit positions used by the FIFO responder.
// ---------------------------------------------------------------------------
package matrix_bus_pkg;

    localparam int DATA_W = 256;
    localparam int ADDR_W = 16;

    // Device-select codes carried in address[15:12]
    localparam logic [3:0] SEL_MEM  = 4'h0;
    localparam logic [3:0] SEL_ALU  = 4'h1;
    localparam logic [3:0] SEL_FIFO = 4'h4;

    // Register offsets carried in address[3:0]
    typedef enum logic [3:0] {
        OFF_DATA   = 4'd0,
        OFF_STATUS = 4'd1,
        OFF_CTRL   = 4'd2
    } off_e;

    // STATUS word layout; count occupies bits [7:0]
    localparam int STS_EMPTY = 8;
    localparam int STS_FULL  = 9;
    localparam int STS_OVF   = 10;
    localparam int STS_UNF   = 11;
    localparam int STS_ERR   = 12;

    // CTRL write bits
    localparam int CTRL_CLR_ALL = 0;
    localparam int CTRL_CLR_STK = 1;

endpackage

// File: rtl/fifo_store.sv
// ---------------------------------------------------------------------------
// fifo_store
// DEPTH x DATA_W register array: one synchronous write port and one
// combinational read port. The array has no reset; the parent owns the
// pointers and only ever reads entries it has written.
// Ports:
//   clk_i    clock
//   we_i     write enable
//   waddr_i  write index
//   wdata_i  write data
//   raddr_i  read index
//   rdata_o  read data (combinational)
// ---------------------------------------------------------------------------
module fifo_store #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 256,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DEPTH-1:0][DATA_W-1:0] mem_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/matrix_bus_fifo.sv
// ---------------------------------------------------------------------------
// matrix_bus_fifo
// Memory-mapped FIFO target on the matrix bus. Writes to DATA push a word,
// reads of DATA pop one with a single cycle of latency. STATUS reports the
// fill level and sticky error flags; CTRL clears the FIFO and/or the flags.
// Each strobe falling edge (while selected) is exactly one access.
// Ports:
//   Clk          rising-edge clock
//   Reset        synchronous active-high reset
//   ExeDataOut   write data from Execution
//   FifoDataOut  read data back to Execution, zero when not being read
//   address      bus address ([15:12] select, [3:0] offset)
//   nRead        active-low read strobe
//   nWrite       active-low write strobe
// ---------------------------------------------------------------------------
module matrix_bus_fifo
    import matrix_bus_pkg::*;
#(
    parameter int         DATA_W   = matrix_bus_pkg::DATA_W,
    parameter int         ADDR_W   = matrix_bus_pkg::ADDR_W,
    parameter int         DEPTH    = 4,
    parameter logic [3:0] BASE_SEL = SEL_FIFO
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] ExeDataOut,
    output logic [DATA_W-1:0] FifoDataOut,
    input  logic [ADDR_W-1:0] address,
    input  logic              nRead,
    input  logic              nWrite
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic              nRead_q, nWrite_q;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d, unf_q, unf_d, err_q, err_d;
    logic [DATA_W-1:0] dout_q, dout_d;

    logic              sel, rd_go, wr_go, full, empty, we;
    logic [3:0]        off;
    logic [DATA_W-1:0] rdata, status_w;

    // Middle address bits are not decoded by this target.
    logic unused_addr;
    assign unused_addr = ^address[ADDR_W-5:4];

    assign sel   = (address[ADDR_W-1 -: 4] == BASE_SEL);
    assign off   = address[3:0];
    assign rd_go = sel & ~nRead  & nRead_q;
    assign wr_go = sel & ~nWrite & nWrite_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    always_comb begin
        status_w            = '0;
        status_w[7:0]       = 8'(count_q);
        status_w[STS_EMPTY] = empty;
        status_w[STS_FULL]  = full;
        status_w[STS_OVF]   = ovf_q;
        status_w[STS_UNF]   = unf_q;
        status_w[STS_ERR]   = err_q;
    end

    fifo_store #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AW(AW)) u_store (
        .clk_i   (Clk),
        .we_i    (we),
        .waddr_i (wr_ptr_q),
        .wdata_i (ExeDataOut),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    // Only one of push/pop/ctrl can happen per cycle because a same-cycle
    // read and write is rejected as an error, so count moves by at most 1.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        err_d    = err_q;
        dout_d   = dout_q;
        we       = 1'b0;

        // Read data is held only while the read strobe stays asserted.
        if (!sel || nRead) dout_d = '0;

        if (rd_go && wr_go) begin
            err_d  = 1'b1;
            dout_d = '0;
        end else if (wr_go) begin
            case (off)
                OFF_DATA: begin
                    if (!full) begin
                        we       = ~Reset;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        count_d  = count_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                OFF_CTRL: begin
                    if (ExeDataOut[CTRL_CLR_ALL]) begin
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
                        count_d  = '0;
                    end
                    if (ExeDataOut[CTRL_CLR_ALL] || ExeDataOut[CTRL_CLR_STK]) begin
                        ovf_d = 1'b0;
                        unf_d = 1'b0;
                        err_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end else if (rd_go) begin
            case (off)
                OFF_DATA: begin
                    if (!empty) begin
                        dout_d   = rdata;
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        count_d  = count_q - 1'b1;
                    end else begin
                        dout_d = '0;
                        unf_d  = 1'b1;
                    end
                end
                OFF_STATUS: dout_d = status_w;
                default:    dout_d = '0;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            nRead_q  <= 1'b1;
            nWrite_q <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            err_q    <= 1'b0;
            dout_q   <= '0;
        end else begin
            nRead_q  <= nRead;
            nWrite_q <= nWrite;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            err_q    <= err_d;
            dout_q   <= dout_d;
        end
    end

    assign FifoDataOut = dout_q;

endmodule

// File: tb/tb_matrix_bus_fifo.sv
// ---------------------------------------------------------------------------
// tb_matrix_bus_fifo
// Directed bench for matrix_bus_fifo with hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_matrix_bus_fifo;

    logic         Clk = 1'b0;
    logic         Reset;
    logic [255:0] ExeDataOut;
    logic [255:0] FifoDataOut;
    logic [15:0]  address;
    logic         nRead, nWrite;

    int n_chk = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    matrix_bus_fifo dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .ExeDataOut  (ExeDataOut),
        .FifoDataOut (FifoDataOut),
        .address     (address),
        .nRead       (nRead),
        .nWrite      (nWrite)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [255:0] d);
        @(negedge Clk);
        address    = a;
        ExeDataOut = d;
        nWrite     = 1'b0;
        @(negedge Clk);
        nWrite     = 1'b1;
    endtask

    // Sample one cycle after the strobe falls, then release it.
    task automatic bus_rd(input logic [15:0] a, output logic [255:0] d);
        @(negedge Clk);
        address = a;
        nRead   = 1'b0;
        @(posedge Clk);
        #1 d = FifoDataOut;
        @(negedge Clk);
        nRead = 1'b1;
    endtask

    logic [255:0] v;

    initial begin
        Reset = 1'b1; ExeDataOut = '0; address = '0; nRead = 1'b1; nWrite = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk) Reset = 1'b0;
        #1 chk("reset_dout", FifoDataOut, '0);
        bus_rd(16'h4001, v); chk("reset_status", v, 256'h100);

        // basic push/pop ordering
        bus_wr(16'h4000, 256'h1);
        bus_wr(16'h4000, 256'h2);
        bus_rd(16'h4000, v); chk("pop_a", v, 256'h1);
        @(posedge Clk); #1 chk("dout_idle", FifoDataOut, '0);
        bus_rd(16'h4000, v); chk("pop_b", v, 256'h2);
        bus_rd(16'h4001, v); chk("status_empty", v, 256'h100);

        // overflow: DEPTH+1 pushes
        for (int i = 0; i < 5; i++) bus_wr(16'h4000, 256'(10 + i));
        bus_rd(16'h4001, v); chk("status_full_ovf", v, 256'h604);
        for (int i = 0; i < 4; i++) begin
            bus_rd(16'h4000, v); chk($sformatf("pop_full_%0d", i), v, 256'(10 + i));
        end
        bus_rd(16'h4001, v); chk("status_drained", v, 256'h500);

        // underflow, then sticky-only clear keeps contents
        bus_rd(16'h4000, v); chk("pop_empty", v, '0);
        bus_wr(16'h4000, 256'h77);
        bus_rd(16'h4001, v); chk("status_unf", v, 256'hC01);
        bus_wr(16'h4002, 256'h2);
        bus_rd(16'h4001, v); chk("status_clr_stk", v, 256'h001);

        // strobe held low 5 cycles: one pop, data held, then back to 0
        bus_wr(16'h4000, 256'h88);
        @(negedge Clk); address = 16'h4000; nRead = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk); #1 chk($sformatf("hold_%0d", i), FifoDataOut, 256'h77);
        end
        @(negedge Clk); nRead = 1'b1;
        @(posedge Clk); #1 chk("hold_release", FifoDataOut, '0);
        bus_rd(16'h4001, v); chk("status_one_pop", v, 256'h001);
        bus_rd(16'h4000, v); chk("pop_after_hold", v, 256'h88);

        // read and write together: error, nothing moves
        bus_wr(16'h4000, 256'h99);
        @(negedge Clk); address = 16'h4000; ExeDataOut = 256'h55; nRead = 1'b0; nWrite = 1'b0;
        @(posedge Clk); #1 chk("both_dout", FifoDataOut, '0);
        @(negedge Clk); nRead = 1'b1; nWrite = 1'b1;
        bus_rd(16'h4001, v); chk("status_err", v, 256'h1001);
        bus_wr(16'h4002, 256'h1);
        bus_rd(16'h4001, v); chk("status_clr_all", v, 256'h100);

        // reset mid-read after three pushes
        for (int i = 0; i < 3; i++) bus_wr(16'h4000, 256'(32'hA0 + i));
        @(negedge Clk); address = 16'h4000; nRead = 1'b0;
        @(posedge Clk); #1 chk("pre_reset_pop", FifoDataOut, 256'hA0);
        @(negedge Clk); Reset = 1'b1;
        @(posedge Clk); #1 chk("reset_mid_dout", FifoDataOut, '0);
        @(negedge Clk); Reset = 1'b0; nRead = 1'b1;
        bus_rd(16'h4001, v); chk("status_after_reset", v, 256'h100);

        // unselected and reserved accesses leave state alone
        for (int i = 0; i < 3; i++) bus_wr(16'h4000, 256'(32'hB0 + i));
        bus_wr(16'h0000, 256'hDEAD);
        bus_wr(16'h0002, 256'h1);
        bus_wr(16'h4005, 256'h1);
        bus_rd(16'h0000, v); chk("unsel_rd", v, '0);
        bus_rd(16'h4005, v); chk("reserved_rd", v, '0);
        bus_rd(16'h4001, v); chk("status_unsel", v, 256'h003);
        bus_rd(16'h4000, v); chk("pop_after_unsel", v, 256'hB0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
